// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: valid/ready bundle between the decode stage and imm_gen_pipe.
// The slave modport is the immediate generator itself; master is the side that
// offers instructions and consumes immediates.
interface imm_gen_pipe_if #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 32,
    parameter int ERRCNT_W = 8
);
    // Input side: instruction, format select and sideband tag.
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         instr;
    logic [2:0]          imm_src;
    logic [TAG_W-1:0]    in_tag;

    // Output side: extended immediate with its tag and error flag.
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     imm_ext;
    logic [TAG_W-1:0]    out_tag;
    logic                imm_err;
    logic [ERRCNT_W-1:0] err_cnt;

    modport master (
        output in_valid, instr, imm_src, in_tag, out_ready,
        input  in_ready, out_valid, imm_ext, out_tag, imm_err, err_cnt
    );

    modport slave (
        input  in_valid, instr, imm_src, in_tag, out_ready,
        output in_ready, out_valid, imm_ext, out_tag, imm_err, err_cnt
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator (I/S/B/J/U/CSR zimm) with a
// one-cycle valid/ready pipeline, pass-through tag, illegal-select flag and a
// saturating illegal-select counter.
// Build option IMM_GEN_PIPE_SKID_EN: main+skid two-entry buffer with a
// registered in_ready. Without it, a single output register whose in_ready
// depends combinationally on out_ready.
module imm_gen_pipe #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 32,
    parameter int ERRCNT_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    imm_gen_pipe_if.slave bus
);
    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_J = 3'b011;
    localparam logic [2:0] SRC_U = 3'b100;
    localparam logic [2:0] SRC_Z = 3'b101;

    logic [31:0]         instr;
    logic [31:0]         imm_raw;
    logic                illegal;
    logic [XLEN-1:0]     imm_wide;
    logic                accept;
    logic [ERRCNT_W-1:0] err_cnt;

    logic                main_valid;
    logic [XLEN-1:0]     main_imm;
    logic [TAG_W-1:0]    main_tag;
    logic                main_err;

    // Opcode bits never feed an immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];
    assign instr = bus.instr;

    // Select the immediate fields; every format yields a 32-bit signed value.
    // NOTE: defaults come before the case so no path leaves an output unassigned (no latch).
    always_comb begin
        imm_raw = '0;
        illegal = 1'b0;
        case (bus.imm_src)
            SRC_I:   imm_raw = {{20{instr[31]}}, instr[31:20]};
            SRC_S:   imm_raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            SRC_B:   imm_raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            SRC_J:   imm_raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            SRC_U:   imm_raw = {instr[31:12], 12'b0};
            SRC_Z:   imm_raw = {27'b0, instr[19:15]};
            default: illegal = 1'b1;
        endcase
    end

    // zimm has bit 31 clear, so a single signed widening covers every format.
    assign imm_wide = XLEN'($signed(imm_raw));

    // Count accepted illegal selects, sticking at all-ones.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (accept && illegal && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERRCNT_W'(1);
        end
    end

`ifdef IMM_GEN_PIPE_SKID_EN
    logic             skid_valid;
    logic             skid_valid_n;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_err;
    logic             ready_q;
    logic             main_free;

    assign main_free    = !main_valid || bus.out_ready;
    assign accept       = bus.in_valid && ready_q;
    // Skid only stays/becomes occupied while main is stalled.
    assign skid_valid_n = main_free ? 1'b0 : (skid_valid || accept);
    assign bus.in_ready = ready_q;

    // Main entry refills from skid first, else from the input; ready tracks skid-empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_imm   <= '0;
            main_tag   <= '0;
            main_err   <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            skid_valid <= skid_valid_n;
            ready_q    <= !skid_valid_n;
            if (main_free) begin
                if (skid_valid) begin
                    main_valid <= 1'b1;
                    main_imm   <= skid_imm;
                    main_tag   <= skid_tag;
                    main_err   <= skid_err;
                end else begin
                    main_valid <= accept;
                    if (accept) begin
                        main_imm <= imm_wide;
                        main_tag <= bus.in_tag;
                        main_err <= illegal;
                    end
                end
            end
        end
    end

    // Park an accepted beat in skid when main cannot advance.
    // NOTE: the skid payload is never reset; skid_valid alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (!main_free && accept) begin
            skid_imm <= imm_wide;
            skid_tag <= bus.in_tag;
            skid_err <= illegal;
        end
    end
`else
    assign bus.in_ready = rst_n && (!main_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Single output register: load on accept, clear valid when drained with no new beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_imm   <= '0;
            main_tag   <= '0;
            main_err   <= 1'b0;
        end else if (bus.in_ready) begin
            main_valid <= bus.in_valid;
            if (bus.in_valid) begin
                main_imm <= imm_wide;
                main_tag <= bus.in_tag;
                main_err <= illegal;
            end
        end
    end
`endif

    assign bus.out_valid = main_valid;
    assign bus.imm_ext   = main_imm;
    assign bus.out_tag   = main_tag;
    assign bus.imm_err   = main_err;
    assign bus.err_cnt   = err_cnt;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe. Two instances run in
// lockstep on the same stimulus: XLEN=32/ERRCNT_W=8 and XLEN=64/ERRCNT_W=2.
module tb_imm_gen_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    typedef struct {
        logic [31:0] e32;
        logic [63:0] e64;
        logic [31:0] tag;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] e32;
        logic [63:0] e64;
    } vec_t;

    exp_t sb[$];
    vec_t fmt[10];
    bit   pat[6] = '{1, 0, 0, 1, 0, 1};

    logic        stalled;
    logic [31:0] h32;
    logic [63:0] h64;
    logic [31:0] htag;
    logic        herr;
    logic        pre_ready;
    int          dummy;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32), .ERRCNT_W(8)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32), .ERRCNT_W(2)) b64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ERRCNT_W(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .ERRCNT_W(2)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    assign b64.in_valid  = b32.in_valid;
    assign b64.instr     = b32.instr;
    assign b64.imm_src   = b32.imm_src;
    assign b64.in_tag    = b32.in_tag;
    assign b64.out_ready = b32.out_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Offer one beat; push its expectation when the handshake is seen.
    task automatic send(input logic [31:0] instr, input logic [2:0] src, input logic [31:0] tag,
                        input logic [31:0] e32, input logic [63:0] e64, input logic err,
                        output int waited);
        exp_t e;
        bit   done = 1'b0;
        e.e32 = e32;
        e.e64 = e64;
        e.tag = tag;
        e.err = err;
        b32.in_valid = 1'b1;
        b32.instr    = instr;
        b32.imm_src  = src;
        b32.in_tag   = tag;
        waited = 0;
        while (!done && waited < 64) begin
            @(negedge clk);
            if (b32.in_ready) begin
                sb.push_back(e);
                done = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        b32.in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout tag=0x%0h not accepted within 64 cycles", tag);
        end
    endtask

    // Wait until every expected beat has left the DUT.
    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || b32.out_valid) && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 64) begin
            checks++;
            failures++;
            $display("FAIL %s drain_timeout pending=%0d required=0", name, sb.size());
        end
    endtask

    // Monitor: compare each delivered beat and verify stability across stalls.
    initial begin
        exp_t e;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_valid", b32.out_valid, 1'b1);
                    check("hold_imm32", b32.imm_ext, h32);
                    check("hold_imm64", b64.imm_ext, h64);
                    check("hold_tag",   b32.out_tag, htag);
                    check("hold_err",   b32.imm_err, herr);
                end
                if (b32.out_valid && b32.out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual_tag=0x%0h required=no beat", b32.out_tag);
                    end else begin
                        e = sb.pop_front();
                        check("imm32",      b32.imm_ext,   e.e32);
                        check("imm64",      b64.imm_ext,   e.e64);
                        check("tag32",      b32.out_tag,   e.tag);
                        check("tag64",      b64.out_tag,   e.tag);
                        check("err32",      b32.imm_err,   e.err);
                        check("err64",      b64.imm_err,   e.err);
                        check("valid64",    b64.out_valid, 1'b1);
                    end
                end
                stalled = b32.out_valid && !b32.out_ready;
                h32  = b32.imm_ext;
                h64  = b64.imm_ext;
                htag = b32.out_tag;
                herr = b32.imm_err;
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        fmt[0] = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF};
        fmt[1] = '{32'h7FF00093, 3'b000, 32'h000007FF, 64'h00000000_000007FF};
        fmt[2] = '{32'hFE512E23, 3'b001, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC};
        fmt[3] = '{32'h00000463, 3'b010, 32'h00000008, 64'h00000000_00000008};
        fmt[4] = '{32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC};
        fmt[5] = '{32'h800000EF, 3'b011, 32'hFFF00000, 64'hFFFFFFFF_FFF00000};
        fmt[6] = '{32'h12345037, 3'b100, 32'h12345000, 64'h00000000_12345000};
        fmt[7] = '{32'h80000037, 3'b100, 32'h80000000, 64'hFFFFFFFF_80000000};
        fmt[8] = '{32'h000FD073, 3'b101, 32'h0000001F, 64'h00000000_0000001F};
        fmt[9] = '{32'h800FD073, 3'b101, 32'h0000001F, 64'h00000000_0000001F};

        b32.in_valid  = 1'b0;
        b32.instr     = '0;
        b32.imm_src   = '0;
        b32.in_tag    = '0;
        b32.out_ready = 1'b1;

        // Reset held for three edges.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_out_valid",  b32.out_valid, 1'b0);
            check("rst_in_ready",   b32.in_ready,  1'b0);
            check("rst_in_ready64", b64.in_ready,  1'b0);
            check("rst_err_cnt",    b32.err_cnt,   8'd0);
            check("rst_imm_ext",    b32.imm_ext,   32'd0);
            check("rst_out_tag",    b32.out_tag,   32'd0);
            check("rst_imm_err",    b32.imm_err,   1'b0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready", b32.in_ready, 1'b1);
        check("release_out_valid", b32.out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Every format, one-cycle latency, no wait with OutReady=1.
        for (int i = 0; i < 10; i++) begin
            send(fmt[i].instr, fmt[i].src, 32'h1000 + i, fmt[i].e32, fmt[i].e64, 1'b0, w);
            check("accept_no_wait", w, 0);
            @(negedge clk);
            check("latency_valid", b32.out_valid, 1'b1);
            check("latency_tag",   b32.out_tag,   32'h1000 + i);
            @(posedge clk);
            #1;
        end
        drain("formats");

        // Illegal selects: zero immediate, error flag, counting.
        for (int i = 0; i < 3; i++) begin
            send(32'hFFFFFFFF, 3'b110, 32'h2000 + i, 32'd0, 64'd0, 1'b1, dummy);
        end
        drain("illegal3");
        check("errcnt_after3",   b32.err_cnt, 8'd3);
        check("errcnt64_after3", b64.err_cnt, 2'd3);
        for (int i = 0; i < 2; i++) begin
            send(32'h12345678, 3'b111, 32'h2100 + i, 32'd0, 64'd0, 1'b1, dummy);
        end
        drain("illegal5");
        check("errcnt_after5",       b32.err_cnt, 8'd5);
        check("errcnt64_saturated",  b64.err_cnt, 2'd3);

        // Backpressure: tags 1..6 while OutReady toggles.
        fork
            begin
                for (int t = 1; t <= 6; t++) begin
                    send({t[11:0], 20'h00093}, 3'b000, t, t, t, 1'b0, dummy);
                end
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(posedge clk);
                    #1;
                    pre_ready = b32.in_ready;
                    b32.out_ready = pat[c % 6];
`ifdef IMM_GEN_PIPE_SKID_EN
                    #1;
                    check("skid_ready_indep", b32.in_ready, pre_ready);
`endif
                end
                @(posedge clk);
                #1;
                b32.out_ready = 1'b1;
            end
        join
        drain("backpressure");

        // Reset while a result (and skid, if present) is stalled.
        b32.out_ready = 1'b0;
        send(32'hFFF00093, 3'b000, 32'h5001, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0, dummy);
`ifdef IMM_GEN_PIPE_SKID_EN
        send(32'h7FF00093, 3'b000, 32'h5002, 32'h000007FF, 64'h7FF, 1'b0, dummy);
`endif
        @(negedge clk);
        check("mid_pre_valid", b32.out_valid, 1'b1);
`ifdef IMM_GEN_PIPE_SKID_EN
        check("mid_pre_skid_full", b32.in_ready, 1'b0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check("mid_out_valid",   b32.out_valid, 1'b0);
        check("mid_out_valid64", b64.out_valid, 1'b0);
        check("mid_err_cnt",     b32.err_cnt,   8'd0);
        check("mid_err_cnt64",   b64.err_cnt,   2'd0);
        check("mid_imm_ext",     b32.imm_ext,   32'd0);
        check("mid_out_tag",     b32.out_tag,   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        b32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'h00100093, 3'b000, 32'h6001, 32'd1, 64'd1, 1'b0, dummy);
        send(32'h00200093, 3'b000, 32'h6002, 32'd2, 64'd2, 1'b0, dummy);
        drain("post_reset");
        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
